// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: source indices, field widths
// and the result bundle every execution unit presents to writeback.
package wb_arbiter_pkg;
    localparam int SRC_ALU  = 0;
    localparam int SRC_BRU  = 1;
    localparam int SRC_LSQ  = 2;
    localparam int NUM_SRC  = 3;

    localparam int ROBID_W  = 8;
    localparam int RD_W     = 6;
    localparam int ECAUSE_W = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic                valid;
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [RD_W-1:0]     rd;
        logic [XLEN-1:0]     result;
    } wb_bundle_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Source-result, stall, flush and broadcast signals of the writeback stage.
// The arbiter takes the slave side; producers and consumers take the master side.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                alu_wb_valid, alu_wb_error;
    logic [ECAUSE_W-1:0] alu_wb_ecause;
    logic [ROBID_W-1:0]  alu_wb_robid;
    logic [RD_W-1:0]     alu_wb_rd;
    logic [XLEN-1:0]     alu_wb_result;
    logic                wb_alu_stall;

    logic                bru_wb_valid, bru_wb_error;
    logic [ECAUSE_W-1:0] bru_wb_ecause;
    logic [ROBID_W-1:0]  bru_wb_robid;
    logic [RD_W-1:0]     bru_wb_rd;
    logic [XLEN-1:0]     bru_wb_result;
    logic                wb_bru_stall;

    logic                lsq_wb_valid, lsq_wb_error;
    logic [ECAUSE_W-1:0] lsq_wb_ecause;
    logic [ROBID_W-1:0]  lsq_wb_robid;
    logic [RD_W-1:0]     lsq_wb_rd;
    logic [XLEN-1:0]     lsq_wb_result;
    logic                wb_lsq_stall;

    logic                rob_flush;

    logic                wb_valid, wb_error;
    logic [ECAUSE_W-1:0] wb_ecause;
    logic [ROBID_W-1:0]  wb_robid;
    logic [RD_W-1:0]     wb_rd;
    logic [XLEN-1:0]     wb_result;

    modport slave (
        input  alu_wb_valid, alu_wb_error, alu_wb_ecause, alu_wb_robid, alu_wb_rd, alu_wb_result,
        input  bru_wb_valid, bru_wb_error, bru_wb_ecause, bru_wb_robid, bru_wb_rd, bru_wb_result,
        input  lsq_wb_valid, lsq_wb_error, lsq_wb_ecause, lsq_wb_robid, lsq_wb_rd, lsq_wb_result,
        input  rob_flush,
        output wb_alu_stall, wb_bru_stall, wb_lsq_stall,
        output wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );

    modport master (
        output alu_wb_valid, alu_wb_error, alu_wb_ecause, alu_wb_robid, alu_wb_rd, alu_wb_result,
        output bru_wb_valid, bru_wb_error, bru_wb_ecause, bru_wb_robid, bru_wb_rd, bru_wb_result,
        output lsq_wb_valid, lsq_wb_error, lsq_wb_ecause, lsq_wb_robid, lsq_wb_rd, lsq_wb_result,
        output rob_flush,
        input  wb_alu_stall, wb_bru_stall, wb_lsq_stall,
        input  wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );
endinterface

// File: rtl/wb_arbiter_rrarb.sv
// Generic N-way round-robin arbiter. Scan starts at the pointer; after a grant
// the pointer moves one past the winner. advance=0 suppresses any grant.
module rrarb #(
    parameter int N        = 3,
    parameter int RR_RESET = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         grant_valid
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr, gidx;
    int            base, idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        gidx        = '0;
        idx         = 0;
        // Out-of-range pointer values (e.g. 3 for N=3) restart the scan at 0.
        base        = (int'(ptr) >= N) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (advance && !grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              ptr <= PW'(RR_RESET);
        else if (grant_valid) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of alu/bru/lsq per cycle round-robin and
// registers it onto the single writeback broadcast bus.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC     = 3,
    parameter int RR_RESET = 0
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    wb_bundle_t      src [NSRC];
    wb_bundle_t      sel;
    wb_bundle_t      wb_q;
    logic [NSRC-1:0] req, grant, stall;
    logic            grant_valid;

    assign src[SRC_ALU] = {bus.alu_wb_valid, bus.alu_wb_error, bus.alu_wb_ecause,
                           bus.alu_wb_robid, bus.alu_wb_rd, bus.alu_wb_result};
    assign src[SRC_BRU] = {bus.bru_wb_valid, bus.bru_wb_error, bus.bru_wb_ecause,
                           bus.bru_wb_robid, bus.bru_wb_rd, bus.bru_wb_result};
    assign src[SRC_LSQ] = {bus.lsq_wb_valid, bus.lsq_wb_error, bus.lsq_wb_ecause,
                           bus.lsq_wb_robid, bus.lsq_wb_rd, bus.lsq_wb_result};

    for (genvar i = 0; i < NSRC; i++) begin : g_req
        assign req[i] = src[i].valid;
    end

    // No grant while flushing or in reset, so every requester sees stall=valid.
    rrarb #(.N(NSRC), .RR_RESET(RR_RESET)) u_rrarb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .advance     (~bus.rob_flush & ~rst),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++)
            if (grant[i]) sel = src[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              wb_q       <= '0;
        else if (grant_valid) wb_q       <= sel;
        else                  wb_q.valid <= 1'b0;
    end

    assign stall            = req & ~grant;
    assign bus.wb_alu_stall = stall[SRC_ALU];
    assign bus.wb_bru_stall = stall[SRC_BRU];
    assign bus.wb_lsq_stall = stall[SRC_LSQ];

    assign bus.wb_valid  = wb_q.valid;
    assign bus.wb_error  = wb_q.error;
    assign bus.wb_ecause = wb_q.ecause;
    assign bus.wb_robid  = wb_q.robid;
    assign bus.wb_rd     = wb_q.rd;
    assign bus.wb_result = wb_q.result;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a
// round-robin reference model of grants, stalls and the broadcast register.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
    wb_arbiter #(.NSRC(3), .RR_RESET(0)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic        sv [3];
    logic        se [3];
    logic [4:0]  sc [3];
    logic [7:0]  sr [3];
    logic [5:0]  sd [3];
    logic [31:0] sx [3];
    logic        flush;
    int          waitc [3];

    int          m_ptr;
    logic [52:0] m_wb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.alu_wb_valid = sv[0]; bus.alu_wb_error = se[0]; bus.alu_wb_ecause = sc[0];
        bus.alu_wb_robid = sr[0]; bus.alu_wb_rd = sd[0]; bus.alu_wb_result = sx[0];
        bus.bru_wb_valid = sv[1]; bus.bru_wb_error = se[1]; bus.bru_wb_ecause = sc[1];
        bus.bru_wb_robid = sr[1]; bus.bru_wb_rd = sd[1]; bus.bru_wb_result = sx[1];
        bus.lsq_wb_valid = sv[2]; bus.lsq_wb_error = se[2]; bus.lsq_wb_ecause = sc[2];
        bus.lsq_wb_robid = sr[2]; bus.lsq_wb_rd = sd[2]; bus.lsq_wb_result = sx[2];
        bus.rob_flush = flush;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 3; i++) begin
            sv[i] = 0; se[i] = 0; sc[i] = 0; sr[i] = 0; sd[i] = 0; sx[i] = 0; waitc[i] = 0;
        end
        flush = 0;
    endtask

    task automatic set_src(input int i, input logic [7:0] robid, input logic [5:0] rd,
                           input logic [31:0] res, input logic err, input logic [4:0] cause);
        sv[i] = 1; sr[i] = robid; sd[i] = rd; sx[i] = res; se[i] = err; sc[i] = cause;
        waitc[i] = 0;
    endtask

    function automatic logic [52:0] wb_bus();
        return {bus.wb_valid, bus.wb_error, bus.wb_ecause, bus.wb_robid, bus.wb_rd, bus.wb_result};
    endfunction

    // One clock: drive, check against the model mid-cycle, advance the model.
    // Accepted sources drop their request afterwards.
    task automatic step();
        int win;
        logic [2:0] exp_st;
        #1 drive();
        @(negedge clk);
        win = -1;
        if (!flush)
            for (int k = 0; k < 3; k++)
                if (win < 0 && sv[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
        for (int i = 0; i < 3; i++) exp_st[i] = sv[i] && (i != win);
        chk("stall", {bus.wb_lsq_stall, bus.wb_bru_stall, bus.wb_alu_stall}, exp_st);
        chk("wb", wb_bus(), m_wb);
        for (int i = 0; i < 3; i++) begin
            if (i == win) begin
                chk("fair", waitc[i] <= 2, 1);
                waitc[i] = 0;
            end else if (sv[i] && !flush) waitc[i]++;
        end
        if (win >= 0) begin
            m_wb  = {1'b1, se[win], sc[win], sr[win], sd[win], sx[win]};
            m_ptr = (win + 1) % 3;
            sv[win] = 0;
        end else m_wb[52] = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst = 1; clear_src(); drive();
        m_ptr = 0; m_wb = '0;
        sv[0] = 1; drive();
        #3;
        chk("rst_stall", bus.wb_alu_stall, 1);
        chk("rst_wb", wb_bus(), 0);
        clear_src(); drive();
        @(negedge clk); rst = 0;
        @(posedge clk);

        // idle after reset
        repeat (10) step();
        #1 chk("idle_wb", wb_bus(), 0);

        // single lsq load
        set_src(2, 8'h15, 6'h07, 32'hDEADBEEF, 0, 0);
        step();
        #1 chk("lsq_wb", {bus.wb_valid, bus.wb_robid, bus.wb_rd, bus.wb_result},
               {1'b1, 8'h15, 6'h07, 32'hDEADBEEF});

        // three-way contention, pointer back at 0
        set_src(0, 8'h01, 6'h01, 32'h11, 0, 0);
        set_src(1, 8'h02, 6'h02, 32'h22, 0, 0);
        set_src(2, 8'h03, 6'h03, 32'h33, 0, 0);
        step(); #1 chk("cont1", {bus.wb_valid, bus.wb_robid}, {1'b1, 8'h01});
        step(); #1 chk("cont2", {bus.wb_valid, bus.wb_robid}, {1'b1, 8'h02});
        step(); #1 chk("cont3", {bus.wb_valid, bus.wb_robid}, {1'b1, 8'h03});

        // wrap: after lsq grant, alu precedes lsq
        set_src(0, 8'h11, 6'h0A, 32'hA0, 0, 0);
        set_src(2, 8'h13, 6'h0C, 32'hC0, 0, 0);
        step(); #1 chk("wrap1", bus.wb_robid, 8'h11);
        step(); #1 chk("wrap2", bus.wb_robid, 8'h13);

        // flush with all valid
        set_src(0, 8'h21, 6'h01, 32'h1, 0, 0);
        set_src(1, 8'h22, 6'h02, 32'h2, 0, 0);
        set_src(2, 8'h23, 6'h03, 32'h3, 0, 0);
        flush = 1;
        step(); #1 chk("flush_v", bus.wb_valid, 0);
        flush = 0;
        step(); #1 chk("post_flush", {bus.wb_valid, bus.wb_robid}, {1'b1, 8'h21});
        step(); step();

        // error pass-through
        set_src(0, 8'h31, 6'h05, 32'h55, 1, 5'h02);
        step();
        #1 chk("err", {bus.wb_valid, bus.wb_error, bus.wb_ecause}, {1'b1, 1'b1, 5'h02});
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if (!sv[i] && $urandom_range(1, 0) == 1)
                    set_src(i, 8'($urandom), 6'($urandom), $urandom, 1'($urandom),
                            5'($urandom));
            flush = ($urandom_range(7, 0) == 0);
            step();
        end
        clear_src();
        step(); step();

        // async reset while a broadcast is live
        set_src(0, 8'h41, 6'h11, 32'h12345678, 0, 0);
        step();
        #2 chk("pre_arst", bus.wb_valid, 1);
        rst = 1;
        #1 chk("arst_wb", wb_bus(), 0);
        set_src(0, 8'h42, 6'h12, 32'h9, 0, 0); drive();
        #1 chk("arst_stall", bus.wb_alu_stall, 1);
        m_ptr = 0; m_wb = '0;
        clear_src(); drive();
        @(negedge clk); rst = 0;
        @(posedge clk);
        set_src(1, 8'h51, 6'h01, 32'h7, 0, 0);
        set_src(2, 8'h52, 6'h02, 32'h8, 0, 0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
